dmem_access_ctrl: RTL

- Sequencer between the MIPS load/store stage and the word-wide DataMemory (Address, r_wbar, WriteData, ReadData).
- Accepts one byte/halfword/word load or store per transaction over a valid/ready handshake.
- Drives the memory word interface, performing read-modify-write for sub-word stores.
- Returns aligned and extended load data, or an error for misaligned or illegal requests.

---
 rtl/dmem_access_ctrl.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl
//   Sequencer between the load/store stage and a word-wide DataMemory with a
//   combinational read port and a write on the rising clock edge.
//   Each request is a byte, halfword or word load or store. Sub-word stores
//   are done as read-modify-write. Loads are returned aligned and sign- or
//   zero-extended. Byte order is big-endian: byte offset 0 is bits 31:24.
//
// Ports
//   clk, reset    rising-edge clock and synchronous active-high reset
//   req_*         request channel (valid/ready). The fields are latched on
//                 the accept edge.
//   resp_*        response channel (valid/ready). rdata is 0 for stores and
//                 for errors. err flags a misaligned request or size 11.
//   mem_addr      word address (byte address >> 2). Only DEPTH_LOG2 bits
//                 are driven; the upper bits are 0.
//   mem_r_wbar    1 = read, 0 = write
//   mem_wdata     word to write
//   mem_rdata     combinational read data from DataMemory
module dmem_access_ctrl #(
   parameter int DEPTH_LOG2 = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [31:0] mem_addr,
   output logic        mem_r_wbar,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      WR,
      RMW_RD,
      RMW_WR,
      RESP
   } state_t;

   state_t      state_reg, state_next;

   // Latched request fields.
   logic        signed_reg;
   logic [1:0]  size_reg;
   logic [1:0]  off_reg;
   logic [15:0] wdata_reg;

   logic [31:0] mem_addr_reg;
   // Holds the store word. For a sub-word store it is the merge buffer: the
   // word read in RMW_RD, with the target lane already replaced.
   logic [31:0] mem_wdata_reg;
   logic [31:0] resp_rdata_reg;
   logic        resp_err_reg;

   logic        accept;
   logic        req_illegal;
   logic [31:0] req_word_addr;
   logic        unused_addr_bits;

   assign accept = req_valid & req_ready;

   always_comb begin
      req_illegal = 1'b0;
      case (req_size)
         SZ_HALF: req_illegal = req_addr[0];
         SZ_WORD: req_illegal = (req_addr[1:0] != 2'b00);
         SZ_BYTE: req_illegal = 1'b0;
         default: req_illegal = 1'b1;
      endcase
   end

   assign req_word_addr    = 32'(req_addr[DEPTH_LOG2+1:2]);
   assign unused_addr_bits = ^req_addr[31:DEPTH_LOG2+2];

   // Byte lanes of the memory word, plus the lane merge for sub-word stores.
   // A halfword covers lanes {0,1} or {2,3}. Its high byte goes to the even
   // lane.
   logic [7:0]  rd_byte [4];
   logic [31:0] merge_word;

   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      logic       lane_hit;
      logic [7:0] lane_data;

      assign rd_byte[gi] = mem_rdata[31-8*gi -: 8];
      assign lane_hit    = (size_reg == SZ_BYTE) ? (off_reg == LANE)
                                                 : (off_reg[1] == LANE[1]);
      assign lane_data   = ((size_reg == SZ_HALF) && !LANE[0]) ? wdata_reg[15:8]
                                                               : wdata_reg[7:0];
      assign merge_word[31-8*gi -: 8] = lane_hit ? lane_data : rd_byte[gi];
   end

   // Aligned and extended load result.
   logic [7:0]  load_byte;
   logic [15:0] load_half;
   logic [31:0] load_data;

   always_comb begin
      load_byte = rd_byte[off_reg];
      load_half = off_reg[1] ? mem_rdata[15:0] : mem_rdata[31:16];
      case (size_reg)
         SZ_BYTE: load_data = {{24{signed_reg & load_byte[7]}}, load_byte};
         SZ_HALF: load_data = {{16{signed_reg & load_half[15]}}, load_half};
         default: load_data = mem_rdata;
      endcase
   end

   // Next-state logic.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (accept) begin
               if (req_illegal)
                  state_next = RESP;
               else if (!req_we)
                  state_next = LOAD;
               else if (req_size == SZ_WORD)
                  state_next = WR;
               else
                  state_next = RMW_RD;
            end
         end
         LOAD:    state_next = RESP;
         WR:      state_next = RESP;
         RMW_RD:  state_next = RMW_WR;
         RMW_WR:  state_next = RESP;
         RESP:    if (resp_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg      <= IDLE;
         signed_reg     <= 1'b0;
         size_reg       <= 2'b00;
         off_reg        <= 2'b00;
         wdata_reg      <= 16'h0;
         mem_addr_reg   <= 32'h0;
         mem_wdata_reg  <= 32'h0;
         resp_rdata_reg <= 32'h0;
         resp_err_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         case (state_reg)
            IDLE: begin
               if (accept) begin
                  signed_reg     <= req_signed;
                  size_reg       <= req_size;
                  off_reg        <= req_addr[1:0];
                  wdata_reg      <= req_wdata[15:0];
                  mem_addr_reg   <= req_word_addr;
                  resp_rdata_reg <= 32'h0;
                  resp_err_reg   <= req_illegal;
                  if (req_we && (req_size == SZ_WORD) && !req_illegal)
                     mem_wdata_reg <= req_wdata;
               end
            end
            LOAD:    resp_rdata_reg <= load_data;
            RMW_RD:  mem_wdata_reg  <= merge_word;
            default: ;
         endcase
      end
   end

   assign req_ready  = (state_reg == IDLE) && !reset;
   assign resp_valid = (state_reg == RESP);
   assign resp_rdata = resp_rdata_reg;
   assign resp_err   = resp_err_reg;
   assign mem_addr   = mem_addr_reg;
   assign mem_wdata  = mem_wdata_reg;
   // Reset forces a read so that an aborted store never reaches memory.
   assign mem_r_wbar = !(((state_reg == WR) || (state_reg == RMW_WR)) && !reset);

endmodule
